// File: rtl/cell_truth_sweep_ctrl.sv
// Truth-table sweep sequencer: walks a combinational cell through every input vector,
// samples its output after a settle time and accumulates mismatches against EXP_TABLE.
module cell_truth_sweep_ctrl #(
  parameter int unsigned N_IN = 6,
  parameter int unsigned SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXP_TABLE = 64'h111F_111F_111F_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_zn,
  output logic [N_IN-1:0] vec_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec,
  output logic            samp_valid,
  output logic [N_IN-1:0] samp_vec,
  output logic            samp_zn
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = N_IN + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_APPLY  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
  localparam logic [N_IN-1:0]  VEC_LAST  = '1;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [N_IN-1:0]  vec_d, first_err_vec_d, samp_vec_d;
  logic [ERR_W-1:0] err_cnt_d;
  logic             busy_d, done_d, pass_d, first_err_valid_d;
  logic             samp_valid_d, samp_zn_d;
  logic             exp_bit, mismatch;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d           = state;
    cnt_d             = cnt;
    vec_d             = vec_o;
    busy_d            = busy;
    done_d            = done;
    pass_d            = pass;
    err_cnt_d         = err_cnt;
    first_err_valid_d = first_err_valid;
    first_err_vec_d   = first_err_vec;
    samp_valid_d      = 1'b0;
    samp_vec_d        = samp_vec;
    samp_zn_d         = samp_zn;
    exp_bit           = EXP_TABLE[vec_o];
    // X/Z on the cell output must count as a failure, hence the case inequality.
    mismatch          = (dut_zn !== exp_bit);

    if (abort && busy) begin
      state_d = S_IDLE;
      vec_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d           = S_APPLY;
            vec_d             = '0;
            cnt_d             = SETTLE_LD;
            err_cnt_d         = '0;
            first_err_valid_d = 1'b0;
            first_err_vec_d   = '0;
            done_d            = 1'b0;
            pass_d            = 1'b0;
            busy_d            = 1'b1;
          end
        end
        S_APPLY: begin
          if (cnt == CNT_W'(1)) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          samp_valid_d = 1'b1;
          samp_vec_d   = vec_o;
          samp_zn_d    = dut_zn;
          if (mismatch) begin
            err_cnt_d = err_cnt + ERR_W'(1);
            if (!first_err_valid) begin
              first_err_valid_d = 1'b1;
              first_err_vec_d   = vec_o;
            end
          end
          if (vec_o == VEC_LAST) begin
            state_d = S_DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            state_d = S_APPLY;
            vec_d   = vec_o + N_IN'(1);
            cnt_d   = SETTLE_LD;
          end
        end
        default: begin
          state_d = S_IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      vec_o           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      samp_valid      <= 1'b0;
      samp_vec        <= '0;
      samp_zn         <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      vec_o           <= vec_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      err_cnt         <= err_cnt_d;
      first_err_valid <= first_err_valid_d;
      first_err_vec   <= first_err_vec_d;
      samp_valid      <= samp_valid_d;
      samp_vec        <= samp_vec_d;
      samp_zn         <= samp_zn_d;
    end
  end

endmodule

// File: tb/tb_cell_truth_sweep_ctrl.sv
// Bench for cell_truth_sweep_ctrl: table of sweep scenarios with a sample scoreboard,
// plus hand-written abort, async-reset and SETTLE=4 sequences.
module tb_cell_truth_sweep_ctrl;

  logic clk, rst;
  logic start_a, abort_a, dut_zn_a;
  logic start_b, abort_b, dut_zn_b;
  int   mode;

  logic [5:0] vec_a, fvec_a, svec_a, vec_b, fvec_b, svec_b;
  logic [6:0] err_a, err_b;
  logic busy_a, done_a, pass_a, fev_a, sv_a, szn_a;
  logic busy_b, done_b, pass_b, fev_b, sv_b, szn_b;

  typedef struct {
    logic [5:0] vec;
    logic       zn;
  } samp_t;
  samp_t sbq[$];

  typedef struct {
    int   mode;
    int   exp_err;
    logic exp_fev;
    int   exp_fvec;
    logic exp_pass;
  } row_t;
  row_t tbl[4];

  int n_cmp = 0;
  int n_bad = 0;

  cell_truth_sweep_ctrl u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .dut_zn(dut_zn_a),
    .vec_o(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_valid(fev_a), .first_err_vec(fvec_a), .samp_valid(sv_a),
    .samp_vec(svec_a), .samp_zn(szn_a)
  );

  cell_truth_sweep_ctrl #(.SETTLE(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .dut_zn(dut_zn_b),
    .vec_o(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_valid(fev_b), .first_err_vec(fvec_b), .samp_valid(sv_b),
    .samp_vec(svec_b), .samp_zn(szn_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic oai222(input logic [5:0] v);
    return ~((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  // Cell model: 0 = good cell, 1 = output stuck at 0, 2 = wrong only at vector 45.
  function automatic logic zn_of(input int m, input logic [5:0] v);
    case (m)
      1:       return 1'b0;
      2:       return (v == 6'd45) ? ~oai222(v) : oai222(v);
      default: return oai222(v);
    endcase
  endfunction

  always_comb dut_zn_a = zn_of(mode, vec_a);
  always_comb dut_zn_b = oai222(vec_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: each strobe must match the next queued vector/zn pair.
  always @(negedge clk) begin
    if (!rst && sv_a) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: strobe vec %0d with empty queue", svec_a);
      end else begin
        samp_t e;
        e = sbq.pop_front();
        chk("sb_vec", 32'(svec_a), 32'(e.vec));
        chk("sb_zn", 32'(szn_a), 32'(e.zn));
      end
    end
  end

  task automatic push_expect(input int m, input int last);
    samp_t e;
    for (int v = 0; v <= last; v++) begin
      e.vec = 6'(v);
      e.zn  = zn_of(m, 6'(v));
      sbq.push_back(e);
    end
  endtask

  task automatic run_sweep(input row_t r);
    int cyc;
    mode = r.mode;
    push_expect(r.mode, 63);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    cyc = 1;
    chk("start_busy", 32'(busy_a), 32'd1);
    chk("start_done_clr", 32'(done_a), 32'd0);
    chk("start_err_clr", 32'(err_a), 32'd0);
    chk("start_fev_clr", 32'(fev_a), 32'd0);
    while (!done_a && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_cycle", 32'(cyc), 32'd193);
    chk("err_cnt", 32'(err_a), 32'(r.exp_err));
    chk("first_err_valid", 32'(fev_a), 32'(r.exp_fev));
    chk("first_err_vec", 32'(fvec_a), 32'(r.exp_fvec));
    chk("pass", 32'(pass_a), 32'(r.exp_pass));
    chk("done_busy", 32'(busy_a), 32'd0);
    chk("done_vec", 32'(vec_a), 32'd0);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    int cyc, run, bad, nruns;
    logic [5:0] prev;
    row_t good;

    tbl[0] = '{mode: 0, exp_err: 0,  exp_fev: 1'b0, exp_fvec: 0,  exp_pass: 1'b1};
    tbl[1] = '{mode: 1, exp_err: 37, exp_fev: 1'b1, exp_fvec: 0,  exp_pass: 1'b0};
    tbl[2] = '{mode: 2, exp_err: 1,  exp_fev: 1'b1, exp_fvec: 45, exp_pass: 1'b0};
    tbl[3] = '{mode: 2, exp_err: 1,  exp_fev: 1'b1, exp_fvec: 45, exp_pass: 1'b0};
    good = tbl[0];

    rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0; mode = 0;
    #1;
    chk("reset_outs", 32'({vec_a, busy_a, done_a, pass_a, err_a, fev_a, fvec_a, sv_a, svec_a, szn_a}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Rows 1..3 each start from DONE of the previous row.
    for (int i = 0; i < 4; i++) run_sweep(tbl[i]);

    // SETTLE=4: each vector held 5 cycles, done after 321.
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 1; run = 1; bad = 0; nruns = 0; prev = vec_b;
    while (busy_b && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy_b && vec_b == prev) begin
        run++;
      end else begin
        if (run != 5) bad++;
        if (busy_b && vec_b != prev + 6'd1) bad++;
        nruns++;
        run = 1;
        prev = vec_b;
      end
    end
    chk("s4_done_cycle", 32'(cyc), 32'd321);
    chk("s4_done", 32'(done_b), 32'd1);
    chk("s4_bad_runs", 32'(bad), 32'd0);
    chk("s4_num_vectors", 32'(nruns), 32'd64);
    chk("s4_pass", 32'(pass_b), 32'd1);

    // Abort sequence: start at cycle 50 ignored, abort at cycle 100.
    mode = 0;
    push_expect(0, 32);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      start_a = (c == 50);
      abort_a = (c == 100);
      @(posedge clk);
      #1;
      if (c == 99) chk("pre_abort_busy", 32'(busy_a), 32'd1);
    end
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_vec", 32'(vec_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_sb_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
    run_sweep(good);

    // Asynchronous reset in the middle of a failing sweep.
    mode = 1;
    push_expect(1, 63);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("pre_rst_err", 32'(err_a), 32'd13);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", 32'({vec_a, busy_a, done_a, pass_a, err_a, fev_a, fvec_a, sv_a, svec_a, szn_a}), 32'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    run_sweep(good);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cell_truth_sweep_ctrl.md
Name: cell_truth_sweep_ctrl

Overview:
- Sequencer that drives a combinational standard cell through every input combination in ascending binary order.
- After each vector it waits a programmable settle time, samples the cell output and compares it against an expected truth table.
- It accumulates a mismatch count and records the first failing vector.
- Sits beside a cell instance (default OAI222_X1: ZN = !((A1|A2)&(B1|B2)&(C1|C2))) in a self-checking cell-characterisation harness.

Parameters:
- N_IN, 6, number of cell inputs; vec_o bit N_IN-1 drives the first pin (A1), bit 0 drives the last pin (C2).
- SETTLE, 2, cycles a vector is held before its sample cycle; legal range 1..15.
- EXP_TABLE, 64'h111F_111F_111F_FFFF, expected output; bit i is the expected ZN for vector i (default is OAI222); width 2**N_IN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin sweep; honoured only in IDLE or DONE.
- abort  in  1  cancel sweep; honoured only while busy.
- dut_zn  in  1  cell output under test.
- vec_o  out  N_IN  vector driven to cell inputs.
- busy  out  1  sweep in progress.
- done  out  1  sweep completed; level, held until start or reset.
- pass  out  1  done && err_cnt==0.
- err_cnt  out  N_IN+1  mismatch count.
- first_err_valid  out  1  at least one mismatch recorded this sweep.
- first_err_vec  out  N_IN  lowest failing vector.
- samp_valid  out  1  one-cycle strobe per compared vector.
- samp_vec  out  N_IN  vector of the current sample.
- samp_zn  out  1  sampled dut_zn.

Behaviour:
- Reset (async, any state): state=IDLE. vec_o, busy, done, pass, err_cnt, first_err_valid, first_err_vec, samp_valid, samp_vec, samp_zn all 0.
- States: IDLE, APPLY, SAMPLE, DONE. All outputs are registered.
- IDLE/DONE + start=1:
  - Next state APPLY; vec_o=0; settle counter=SETTLE.
  - Clear err_cnt, first_err_valid, first_err_vec, done; busy=1.
- APPLY:
  - vec_o held; counter decrements each cycle.
  - When counter reaches 1 → SAMPLE. APPLY therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle), at the closing edge:
  - samp_vec=vec_o, samp_zn=dut_zn, samp_valid=1 for the next cycle only.
  - Mismatch when dut_zn !== EXP_TABLE[vec_o]; X/Z on dut_zn counts as a mismatch.
  - On mismatch: err_cnt+1. If first_err_valid=0, latch first_err_vec=vec_o and set first_err_valid=1.
  - If vec_o == all-ones → DONE, busy=0, done=1. vec_o returns to 0 on entry to DONE.
  - Otherwise vec_o+1, counter=SETTLE → APPLY.
- Period: SETTLE+1 cycles per vector. done rises 1 + 2**N_IN*(SETTLE+1) cycles after the edge that samples start (193 at defaults).
- err_cnt never wraps: max 2**N_IN fits in N_IN+1 bits.
- start while busy: ignored.
- abort while busy:
  - Next state IDLE; vec_o=0; busy=0; done=0.
  - Counters keep their partial values until the next start.
- abort and start in the same cycle: abort wins if busy, start wins otherwise.
- abort in IDLE/DONE: ignored.
- Re-arming: start in DONE restarts the sweep from vector 0; no pass through IDLE.
- pass is combinational-free: registered as done && (err_cnt==0) on DONE entry.

Test Plan:
- Correct OAI222 model, defaults, start pulse → 64 samp_valid strobes with samp_vec 0..63 in order; done=1 and pass=1 exactly 193 cycles after start; err_cnt=0; first_err_valid=0.
- dut_zn tied to 0 → err_cnt=37; first_err_vec=6'b000000; pass=0.
- Model with output inverted only at vector 6'b101101 → err_cnt=1; first_err_vec=45; samp_zn=1 at that strobe.
- SETTLE=4, correct model → done after 1+64*5=321 cycles. Check vec_o is stable for exactly 5 cycles per vector.
- start pulsed at cycle 50 is ignored. abort at cycle 100 → busy=0, vec_o=0, done=0 next cycle. A fresh start then completes with pass=1.
- rst asserted mid-sweep asynchronously → all outputs 0 before the next clock edge. start in DONE → done clears next cycle and the full sweep repeats with identical results.
